burst_ram_responder: RTL

//  Responder end of the burst RAM command interface (br_*) that cache line fill/evict logic drives.

---
 rtl/burst_ram_pkg.sv | 15 +
 rtl/bram_be64.sv | 44 ++++
 rtl/burst_ram_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/burst_ram_pkg.sv
// Shared types for the burst RAM responder: controller states and data-beat typedefs.
package burst_ram_pkg;

    typedef enum logic [2:0] {
        CALIB,
        IDLE,
        WRITE,
        READ_WAIT,
        READ_BURST
    } state_t;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  mask_t;

endpackage

// File: rtl/bram_be64.sv
// 64-bit simple dual-port RAM with per-byte write masking and a registered read port.
// A mask bit of 1 protects that byte. Read data holds until the next read is issued.
module bram_be64
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  logic [DEPTH_BITWIDTH-1:0] waddr_i,
    input  logic [63:0]               wdata_i,
    input  logic [7:0]                wmask_i,
    input  logic                      re_i,
    input  logic [DEPTH_BITWIDTH-1:0] raddr_i,
    output logic [63:0]               rdata_o
);

    word_t       mem_q [2**DEPTH_BITWIDTH];
    logic [63:0] rdata_q;

    // Storage array: byte-masked writes, never cleared by reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (!wmask_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register: loads only when a read is issued, so the last beat is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram_responder.sv
// BRAM-backed responder for the br_* burst command interface. Mimics the PSRAM controller:
// calibration delay, fixed read latency, wrapping bursts, minimum command spacing.
// BURST_COUNT must be a power of two >= 2 and READ_LATENCY >= 2.
module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int ADDR_BITWIDTH    = 21,
    parameter int DEPTH_BITWIDTH   = 12,
    parameter int BURST_COUNT      = 4,
    parameter int READ_LATENCY     = 12,
    parameter int COMMAND_INTERVAL = 14,
    parameter int CALIB_CYCLES     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_cmd,
    input  logic                     br_cmd_en,
    input  logic [ADDR_BITWIDTH-1:0] br_addr,
    input  logic [63:0]              br_wr_data,
    input  logic [7:0]               br_data_mask,
    output logic [63:0]              br_rd_data,
    output logic                     br_rd_data_valid,
    output logic                     init_calib,
    output logic                     busy,
    output logic                     protocol_error
);

    localparam int B  = $clog2(BURST_COUNT);
    localparam int BW = B + 1;
    localparam int DW = DEPTH_BITWIDTH;
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int IW = $clog2(COMMAND_INTERVAL + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);

    localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
    localparam logic [IW-1:0] IVL_LOAD   = IW'(COMMAND_INTERVAL - 1);
    // One cycle of the latency is spent in the first READ_BURST cycle (RAM read issue).
    localparam logic [LW-1:0] LAT_LOAD   = LW'(READ_LATENCY - 2);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BURST_COUNT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   calib_q, calib_d;
    logic [IW-1:0]   ivl_q,   ivl_d;
    logic [LW-1:0]   lat_q,   lat_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [DW-1:0]   addr_q,  addr_d;
    logic            valid_q, valid_d;
    logic            perr_q,  perr_d;

    logic            accept;
    logic            ram_we, ram_re;
    logic [DW-1:0]   ram_waddr, ram_raddr;
    logic [DW-1:0]   cur_word;

    // Address bits above the storage depth alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^br_addr[ADDR_BITWIDTH-1:DW];

    // Beat k stays inside the aligned BURST_COUNT-word block of the start address.
    function automatic logic [DW-1:0] beat_word(input logic [DW-1:0] base, input logic [BW-1:0] k);
        logic [DW-1:0] w;
        w        = base;
        w[B-1:0] = base[B-1:0] + k[B-1:0];
        return w;
    endfunction

    assign cur_word   = beat_word(addr_q, beat_q);
    assign init_calib = (state_q != CALIB);
    assign busy       = (state_q != IDLE) || (ivl_q != '0);
    assign accept     = br_cmd_en && (state_q == IDLE) && (ivl_q == '0);

    // Next-state logic: sequencing, counters and RAM port control.
    always_comb begin
        state_d   = state_q;
        calib_d   = calib_q;
        ivl_d     = ivl_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = cur_word;
        ram_raddr = cur_word;

        if (ivl_q != '0) begin
            ivl_d = ivl_q - IW'(1);
        end
        if (br_cmd_en && !accept) begin
            perr_d = 1'b1;
        end

        case (state_q)
            CALIB: begin
                if (calib_q == CALIB_LAST) begin
                    state_d = IDLE;
                end else begin
                    calib_d = calib_q + CW'(1);
                end
            end
            IDLE: begin
                if (accept) begin
                    ivl_d  = IVL_LOAD;
                    addr_d = br_addr[DW-1:0];
                    if (br_cmd) begin
                        // Beat 0 is written in the accept cycle itself.
                        ram_we    = 1'b1;
                        ram_waddr = br_addr[DW-1:0];
                        beat_d    = BW'(1);
                        state_d   = WRITE;
                    end else begin
                        lat_d   = LAT_LOAD;
                        beat_d  = '0;
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                ram_we = 1'b1;
                beat_d = beat_q + BW'(1);
                if (beat_q == BEAT_LAST) begin
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                if (lat_q == '0) begin
                    state_d = READ_BURST;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            READ_BURST: begin
                ram_re  = 1'b1;
                valid_d = 1'b1;
                beat_d  = beat_q + BW'(1);
                if (beat_q == BEAT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CALIB;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CALIB;
            calib_q <= '0;
            ivl_q   <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            calib_q <= calib_d;
            ivl_q   <= ivl_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    bram_be64 #(
        .DEPTH_BITWIDTH(DW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (br_wr_data),
        .wmask_i (br_data_mask),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (br_rd_data)
    );

    assign br_rd_data_valid = valid_q;
    assign protocol_error   = perr_q;

endmodule
